// File: rtl/tt_um_gate_array.sv
// tt_um_gate_array: WIDTH-bit registered logic unit with selectable bitwise
// gate or free-running toggle, plus a 4-bit count of result changes.
module tt_um_gate_array #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned SYNC_W = 2 * WIDTH + 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CHG_W  = 4;
  localparam logic [2:0]  OP_TOGGLE = 3'b111;

  // Synchroniser word layout: {hold, op[2:0], B, A}
  logic [SYNC_W-1:0] sync_in;
  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0] sync_out;

  logic [WIDTH-1:0]  a_s;
  logic [WIDTH-1:0]  b_s;
  logic [2:0]        op_s;
  logic              hold_s;

  logic [WIDTH-1:0]  gate_res;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CHG_W-1:0]  chg_q;
  logic [CHG_W-1:0]  chg_d;

  logic              unused_inputs;

  assign sync_in  = {uio_in[3], uio_in[2:0], ui_in[4 +: WIDTH], ui_in[WIDTH-1:0]};
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign a_s      = sync_out[WIDTH-1:0];
  assign b_s      = sync_out[WIDTH +: WIDTH];
  assign op_s     = sync_out[2*WIDTH +: 3];
  assign hold_s   = sync_out[2*WIDTH+3];

  // Enable and spare pins are intentionally unused
  assign unused_inputs = ^{ena, ui_in, uio_in[7:4]};

  // Input synchroniser chain; reset discards its contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Bitwise gate selected by the synchronised opcode
  always_comb begin
    gate_res = '0;
    unique case (op_s)
      3'b000:  gate_res = ~a_s;
      3'b001:  gate_res = a_s & b_s;
      3'b010:  gate_res = a_s | b_s;
      3'b011:  gate_res = a_s ^ b_s;
      3'b100:  gate_res = ~(a_s & b_s);
      3'b101:  gate_res = ~(a_s | b_s);
      3'b110:  gate_res = ~(a_s ^ b_s);
      default: gate_res = r_q;
    endcase
  end

  // Next result, toggle divider and change counter; hold freezes everything
  always_comb begin
    r_d   = r_q;
    cnt_d = cnt_q;
    chg_d = chg_q;
    if (!hold_s) begin
      if (op_s == OP_TOGGLE) begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          r_d   = ~r_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        r_d   = gate_res;
        cnt_d = '0;
      end
    end
    if (r_d != r_q) begin
      chg_d = chg_q + CHG_W'(1);
    end
  end

  // Result, divider and change-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      cnt_q <= '0;
      chg_q <= '0;
    end else begin
      r_q   <= r_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end

  assign uo_out  = 8'(r_q);
  assign uio_out = {chg_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_gate_array.sv
// Bench for tt_um_gate_array: directed scenarios plus randomized run against
// a behavioural model; a second narrow instance covers WIDTH=1/SYNC_STAGES=1.
module tb_tt_um_gate_array;

  localparam int DIV  = 4;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'hFF;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] ui1 = 8'h00;
  logic [7:0] uio1 = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;
  wire  [7:0] uo1, uio_out1, uio_oe1;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [11:0] hist[$];
  logic [3:0]  m_r;
  logic [3:0]  m_chg;
  int          m_ticks;

  tt_um_gate_array #(.WIDTH(4), .SYNC_STAGES(SYNC), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_gate_array #(.WIDTH(1), .SYNC_STAGES(1), .DIV(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui1), .uo_out(uo1),
    .uio_in(uio1), .uio_out(uio_out1), .uio_oe(uio_oe1)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gate_fn(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Advance the model by one clock edge given the inputs seen before it
  task automatic model_edge(input logic [7:0] ui, input logic [7:0] uio, input logic rst);
    logic [11:0] used;
    logic [3:0]  old;
    if (!rst) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(12'h000);
      m_r = 4'h0;
      m_chg = 4'h0;
      m_ticks = 0;
      return;
    end
    hist.push_back({uio[3:0], ui});
    used = hist.pop_front();
    old = m_r;
    if (!used[11]) begin
      if (used[10:8] == 3'd7) begin
        m_ticks++;
        if (m_ticks % DIV == 0) m_r = ~m_r;
      end else begin
        m_ticks = 0;
        m_r = gate_fn(used[10:8], used[3:0], used[7:4]);
      end
    end
    if (m_r != old) m_chg = m_chg + 4'd1;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    logic [7:0] ui_now;
    logic [7:0] uio_now;
    logic       rst_now;
    ui_now = ui_in;
    uio_now = uio_in;
    rst_now = rst_n;
    @(posedge clk);
    #1;
    model_edge(ui_now, uio_now, rst_now);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ui_in = 8'hFF; uio_in = 8'h00;
    step(); step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio: got %h expected 00", uio_out); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_oe: got %h expected f0", uio_oe); end
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL release_uo: got %h expected 00", uo_out); end
    // Zeroed synchroniser gives ~0 for two edges before A=F arrives: two changes
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL release_chg: got %h expected 20", uio_out); end
  endtask

  task automatic test_gate_sweep();
    logic [3:0] exp_v [7];
    logic [3:0] prev;
    exp_v = '{4'h3, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9};
    prev = 4'h0;
    ui_in = 8'hAC;
    for (int i = 0; i < 7; i++) begin
      uio_in = 8'(i);
      step(); step();
      checks++; if (uo_out !== {4'h0, prev}) begin errors++; $display("FAIL sweep_early op=%0d: got %h expected %h", i, uo_out, prev); end
      step();
      checks++; if (uo_out !== {4'h0, exp_v[i]}) begin errors++; $display("FAIL sweep op=%0d: got %h expected %h", i, uo_out, exp_v[i]); end
      prev = exp_v[i];
    end
  endtask

  task automatic test_toggle_and_hold();
    logic [3:0] base;
    ui_in = 8'hAF; uio_in = 8'h00;
    repeat (3) step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL toggle_pre: got %h expected 00", uo_out); end
    base = m_chg;
    uio_in = 8'h07;
    repeat (5) step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL toggle_early: got %h expected 00", uo_out); end
    step();
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("FAIL toggle_flip1: got %h expected 0f", uo_out); end
    checks++; if (uio_out[7:4] !== 4'(base + 1)) begin errors++; $display("FAIL toggle_chg1: got %h expected %h", uio_out[7:4], 4'(base + 1)); end
    repeat (3) step();
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("FAIL toggle_mid: got %h expected 0f", uo_out); end
    step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL toggle_flip2: got %h expected 00", uo_out); end
    checks++; if (uio_out[7:4] !== 4'(base + 2)) begin errors++; $display("FAIL toggle_chg2: got %h expected %h", uio_out[7:4], 4'(base + 2)); end
    // Hold lands while the divider sits at 2
    uio_in = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (uo_out !== 8'h00 || uio_out[7:4] !== 4'(base + 2)) begin
        errors++; $display("FAIL hold_frozen cyc=%0d: got uo=%h chg=%h expected uo=00 chg=%h", i, uo_out, uio_out[7:4], 4'(base + 2));
      end
    end
    uio_in = 8'h07;
    repeat (3) step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL hold_resume_early: got %h expected 00", uo_out); end
    step();
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("FAIL hold_resume_flip: got %h expected 0f", uo_out); end
    checks++; if (uio_out[7:4] !== 4'(base + 3)) begin errors++; $display("FAIL hold_resume_chg: got %h expected %h", uio_out[7:4], 4'(base + 3)); end
  endtask

  task automatic test_chg_wrap();
    logic [3:0] base;
    ui_in = 8'h00; uio_in = 8'h00;
    repeat (4) step();
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("FAIL wrap_pre: got %h expected 0f", uo_out); end
    base = m_chg;
    for (int k = 0; k < 17; k++) begin
      ui_in = (k % 2 == 0) ? 8'h0F : 8'h00;
      step();
    end
    repeat (3) step();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL wrap_r: got %h expected 00", uo_out); end
    checks++; if (uio_out[7:4] !== 4'(base + 17)) begin errors++; $display("FAIL wrap_chg: got %h expected %h", uio_out[7:4], 4'(base + 17)); end
  endtask

  task automatic test_reset_mid_toggle();
    ui_in = 8'h00; uio_in = 8'h0F;
    repeat (3) step();
    uio_in = 8'h07;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    checks++; if (uo_out !== 8'h00 || uio_out !== 8'h00) begin errors++; $display("FAIL midrst_state: got uo=%h uio=%h expected 00 00", uo_out, uio_out); end
    rst_n = 1'b1;
    step();
    checks++; if (uo_out !== 8'h0F || uio_out !== 8'h10) begin errors++; $display("FAIL midrst_first: got uo=%h uio=%h expected 0f 10", uo_out, uio_out); end
    repeat (4) step();
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("FAIL midrst_early: got %h expected 0f", uo_out); end
    step();
    checks++; if (uo_out !== 8'h00 || uio_out !== 8'h20) begin errors++; $display("FAIL midrst_flip: got uo=%h uio=%h expected 00 20", uo_out, uio_out); end
  endtask

  task automatic test_width1();
    checks++; if (uo1 !== 8'h01) begin errors++; $display("FAIL w1_idle: got %h expected 01", uo1); end
    ui1 = 8'h01;
    step();
    checks++; if (uo1 !== 8'h01) begin errors++; $display("FAIL w1_early: got %h expected 01", uo1); end
    step();
    checks++; if (uo1 !== 8'h00) begin errors++; $display("FAIL w1_lat: got %h expected 00", uo1); end
    ui1 = 8'h00;
    step();
    checks++; if (uo1 !== 8'h00) begin errors++; $display("FAIL w1_early2: got %h expected 00", uo1); end
    step();
    checks++; if (uo1 !== 8'h01) begin errors++; $display("FAIL w1_lat2: got %h expected 01", uo1); end
    uio1 = 8'h07;
    repeat (3) step();
    checks++; if (uo1 !== 8'h01) begin errors++; $display("FAIL w1_tog_early: got %h expected 01", uo1); end
    step();
    checks++; if (uo1 !== 8'h00) begin errors++; $display("FAIL w1_tog_flip: got %h expected 00", uo1); end
    checks++; if (uio_out1 !== 8'h40 || uio_oe1 !== 8'hF0) begin errors++; $display("FAIL w1_chg_oe: got uio=%h oe=%h expected 40 f0", uio_out1, uio_oe1); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic       hold;
    op = 3'd7;
    hold = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) hold = ~hold;
      ui_in = 8'($urandom);
      uio_in = {4'($urandom), hold, op};
      rst_n = ($urandom_range(0, 199) != 0);
      step();
      checks++; if (uo_out !== {4'h0, m_r} || uio_out !== {m_chg, 4'h0} || uio_oe !== 8'hF0) begin
        errors++; $display("FAIL random cyc=%0d: got uo=%h uio=%h oe=%h expected uo=%h uio=%h oe=f0", i, uo_out, uio_out, uio_oe, {4'h0, m_r}, {m_chg, 4'h0});
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_gate_sweep();
    test_toggle_and_hold();
    test_chg_wrap();
    test_reset_mid_toggle();
    test_width1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
